// File: rtl/msg_pkg.sv
// Shared types and constants for the UART message deframer.
// Frame states, default sync byte, command codes and checksum fold.
package msg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_CMD,
        S_DATA,
        S_CSUM,
        S_HOLD
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h7E;
    localparam logic [7:0] CMD_DM_ENABLE = 8'hA8;
    localparam logic [7:0] CMD_DM_SET    = 8'hAC;

    function automatic logic [7:0] xor_fold(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/byte_timeout_ctr.sv
// Inter-byte timeout counter: saturates at TIMEOUT_CYC-1 while enabled.
// expired is suppressed in any cycle that also clears the count.
module byte_timeout_ctr #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic CLK,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = en && !clr && (cnt_q == LAST);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_msg_deframer.sv
// Receive-side framer: SYNC, LEN, CMD, payload, optional XOR checksum.
// Good frames are held on a valid/ready port; each error class pulses.
module uart_msg_deframer
    import msg_pkg::*;
#(
    parameter int         MAX_LEN     = 8,
    parameter bit         CSUM_EN     = 1'b1,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         frm_valid,
    input  logic                         frm_ready,
    output logic [7:0]                   frm_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] frm_len,
    output logic [8*MAX_LEN-1:0]         frm_data,
    output logic                         err_len,
    output logic                         err_csum,
    output logic                         err_timeout,
    output logic                         err_ovr,
    output logic                         busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [LW-1:0] plen_q, plen_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    buf_q [MAX_LEN];
    logic [7:0]    buf_d [MAX_LEN];
    logic          err_len_q, err_len_d;
    logic          err_csum_q, err_csum_d;
    logic          err_to_q, err_to_d;
    logic          err_ovr_q, err_ovr_d;

    logic          busy_w;
    logic          expired;
    logic          len_ok;
    logic          last_data;
    logic [LW-1:0] idx_ext;
    state_e        tail_s;

    assign busy_w    = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign len_ok    = (rx_data != 8'd0) &&
                       (32'(rx_data) <= 32'(MAX_LEN + 1));
    assign idx_ext   = LW'(idx_q);
    assign last_data = ((idx_ext + LW'(1)) == plen_q);
    assign tail_s    = CSUM_EN ? S_CSUM : S_HOLD;

    byte_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .CLK    (CLK),
        .reset  (reset),
        .clr    (rx_valid | ~busy_w),
        .en     (busy_w),
        .expired(expired)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        plen_d     = plen_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        buf_d      = buf_q;
        err_len_d  = 1'b0;
        err_csum_d = 1'b0;
        err_to_d   = 1'b0;
        err_ovr_d  = 1'b0;
        if (expired) begin
            state_d  = S_IDLE;
            err_to_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        if (len_ok) begin
                            plen_d  = LW'(rx_data - 8'd1);
                            csum_d  = rx_data;
                            idx_d   = '0;
                            buf_d   = '{default: '0};
                            state_d = S_CMD;
                        end else begin
                            err_len_d = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
                S_CMD: begin
                    if (rx_valid) begin
                        cmd_d   = rx_data;
                        csum_d  = xor_fold(csum_q, rx_data);
                        state_d = (plen_q == '0) ? tail_s : S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        buf_d[idx_q] = rx_data;
                        csum_d       = xor_fold(csum_q, rx_data);
                        idx_d        = idx_q + 1'b1;
                        if (last_data) begin
                            state_d = tail_s;
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum_q) begin
                            state_d = S_HOLD;
                        end else begin
                            err_csum_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    // Bytes seen while holding are dropped, even in the handshake cycle
                    err_ovr_d = rx_valid;
                    if (frm_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            plen_q     <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            buf_q      <= '{default: '0};
            err_len_q  <= 1'b0;
            err_csum_q <= 1'b0;
            err_to_q   <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            plen_q     <= plen_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            buf_q      <= buf_d;
            err_len_q  <= err_len_d;
            err_csum_q <= err_csum_d;
            err_to_q   <= err_to_d;
            err_ovr_q  <= err_ovr_d;
        end
    end

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_flat
        assign frm_data[8*i +: 8] = buf_q[i];
    end

    assign frm_valid   = (state_q == S_HOLD);
    assign frm_cmd     = cmd_q;
    assign frm_len     = plen_q;
    assign err_len     = err_len_q;
    assign err_csum    = err_csum_q;
    assign err_timeout = err_to_q;
    assign err_ovr     = err_ovr_q;
    assign busy        = busy_w;

endmodule
